clapton_stim_driver: RTL

- Initiator-side companion for the 4-bit register/mux-tree selector block (inputs A_e/B_e/C_e, registered single-bit Yout).
- Accepts a request containing an A word, a C word, a starting select code and a step count.
- Drives one select code per cycle on B_e, collects the returned Yout bits after the selector's fixed pipeline latency, and returns them packed as one response word.
- Sits between the test/control logic and the selector; owns all sequencing and capture alignment.

---
 rtl/clapton_stim_driver.sv | 125 ++++++++++++
 1 files changed

// File: rtl/clapton_stim_driver.sv
// Sequences one select code per cycle into the selector and gathers its Yout bits into a single response word.
// The response appears L+LATENCY cycles after acceptance. It is held until resp_ready, and no request is accepted outside IDLE.
module clapton_stim_driver #(
  parameter int LATENCY = 2,
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_a,
  input  logic [3:0]         req_c,
  input  logic [3:0]         req_sel_base,
  input  logic [3:0]         req_len,
  output logic [3:0]         A_e,
  output logic [3:0]         B_e,
  output logic [3:0]         C_e,
  input  logic               Yout,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [MAX_LEN-1:0] resp_data,
  output logic [3:0]         resp_len,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;
  localparam logic [3:0] MAX_L    = 4'(MAX_LEN);

  logic [1:0]         state_q, state_d;
  logic [3:0]         len_q, cnt_q, eff_len;
  logic [3:0]         a_q, b_q, c_q;
  logic [MAX_LEN-1:0] resp_data_q;
  logic [3:0]         resp_len_q;
  logic [LATENCY-1:0] tag_vld_q;
  logic [3:0]         tag_idx_q [LATENCY];
  logic               last_step, last_cap;

  assign eff_len   = (req_len > MAX_L) ? MAX_L : req_len;
  assign last_step = (cnt_q == len_q - 4'd1);
  // The final tag reaching the capture point marks the end of the drain.
  assign last_cap  = tag_vld_q[LATENCY-1] && (tag_idx_q[LATENCY-1] == len_q - 4'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = (eff_len == 4'd0) ? ST_RESP : ST_DRIVE;
      ST_DRIVE: if (last_step) state_d = ST_DRAIN;
      ST_DRAIN: if (last_cap) state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      resp_data_q <= '0;
      resp_len_q  <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < LATENCY; i++) tag_idx_q[i] <= '0;
    end else begin
      state_q <= state_d;

      // Tag for step cnt enters while that step is on the bus.
      tag_vld_q[0] <= (state_q == ST_DRIVE);
      tag_idx_q[0] <= cnt_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end

      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            len_q       <= eff_len;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_len_q  <= '0;
            if (eff_len != 4'd0) begin
              a_q <= req_a;
              b_q <= req_sel_base;
              c_q <= req_c;
            end
          end
        end
        ST_DRIVE: begin
          cnt_q <= cnt_q + 4'd1;
          if (last_step) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
          end else begin
            b_q <= b_q + 4'd1;
          end
        end
        ST_DRAIN: if (last_cap) resp_len_q <= len_q;
        default: ;
      endcase

      if (tag_vld_q[LATENCY-1]) begin
        for (int k = 0; k < MAX_LEN; k++) begin
          if (tag_idx_q[LATENCY-1] == 4'(k)) resp_data_q[k] <= Yout;
        end
      end
    end
  end

  assign A_e        = a_q;
  assign B_e        = b_q;
  assign C_e        = c_q;
  assign resp_data  = resp_data_q;
  assign resp_len   = resp_len_q;
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);

endmodule
